// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised pipeline stage register with handshake, flush and optional skid entry
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int LANES  = 2,
    parameter int ADDR_W = 5,
    parameter int CTRL_W = 2,
    parameter int SKID   = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic                    flush_i,
    input  logic [CTRL_W-1:0]       ctrl_i,
    input  logic [LANES*DATA_W-1:0] lanes_i,
    input  logic [ADDR_W-1:0]       rd_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [CTRL_W-1:0]       ctrl_o,
    output logic [LANES*DATA_W-1:0] lanes_o,
    output logic [ADDR_W-1:0]       rd_o
);

    // bit 0 = main entry valid, bit 1 = skid entry valid; both outputs come straight off flops
    typedef enum logic [1:0] {
        S_EMPTY     = 2'b00,
        S_FULL      = 2'b01,
        S_FULL_SKID = 2'b11
    } state_e;

    state_e                    state_q, state_d;
    logic [1:0]                state_bits;
    logic [CTRL_W-1:0]         ctrl_q, ctrl_d;
    logic [LANES*DATA_W-1:0]   lanes_q, lanes_d;
    logic [ADDR_W-1:0]         rd_q, rd_d;
    logic [CTRL_W-1:0]         skid_ctrl_q, skid_ctrl_d;
    logic [LANES*DATA_W-1:0]   skid_lanes_q, skid_lanes_d;
    logic [ADDR_W-1:0]         skid_rd_q, skid_rd_d;
    logic                      accept;
    logic                      pop;

    assign state_bits  = state_q;
    assign out_valid_o = state_bits[0];
    assign ctrl_o      = ctrl_q;
    assign lanes_o     = lanes_q;
    assign rd_o        = rd_q;

    // ready is a flop with the skid entry; without it, ready looks through to the downstream
    generate
        if (SKID != 0) begin : g_skid_ready
            assign in_ready_o = ~state_bits[1];
        end else begin : g_comb_ready
            assign in_ready_o = ~state_bits[0] | out_ready_i;
        end
    endgenerate

    assign accept = in_valid_i & in_ready_o;
    assign pop    = out_valid_o & out_ready_i;

    // next-state and datapath: flush wins over everything, control is zeroed whenever main empties
    always_comb begin
        state_d      = state_q;
        ctrl_d       = ctrl_q;
        lanes_d      = lanes_q;
        rd_d         = rd_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_lanes_d = skid_lanes_q;
        skid_rd_d    = skid_rd_q;
        if (flush_i) begin
            state_d     = S_EMPTY;
            ctrl_d      = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d = S_FULL;
                        ctrl_d  = ctrl_i;
                        lanes_d = lanes_i;
                        rd_d    = rd_i;
                    end
                end
                S_FULL: begin
                    if (accept && pop) begin
                        ctrl_d  = ctrl_i;
                        lanes_d = lanes_i;
                        rd_d    = rd_i;
                    end else if (accept && (SKID != 0)) begin
                        state_d      = S_FULL_SKID;
                        skid_ctrl_d  = ctrl_i;
                        skid_lanes_d = lanes_i;
                        skid_rd_d    = rd_i;
                    end else if (pop) begin
                        state_d = S_EMPTY;
                        ctrl_d  = '0;
                    end
                end
                S_FULL_SKID: begin
                    if (pop) begin
                        state_d     = S_FULL;
                        ctrl_d      = skid_ctrl_q;
                        lanes_d     = skid_lanes_q;
                        rd_d        = skid_rd_q;
                        skid_ctrl_d = '0;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                    ctrl_d  = '0;
                end
            endcase
        end
    end

    // state and payload registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_EMPTY;
            ctrl_q       <= '0;
            lanes_q      <= '0;
            rd_q         <= '0;
            skid_ctrl_q  <= '0;
            skid_lanes_q <= '0;
            skid_rd_q    <= '0;
        end else begin
            state_q      <= state_d;
            ctrl_q       <= ctrl_d;
            lanes_q      <= lanes_d;
            rd_q         <= rd_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_lanes_q <= skid_lanes_d;
            skid_rd_q    <= skid_rd_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg, skid and non-skid builds side by side
module tb_pipe_stage_reg;

    typedef logic [70:0] pkt_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  ctrl_i = '0;
    logic [63:0] lanes_i = '0;
    logic [4:0]  rd_i = '0;

    logic        in_ready [2];
    logic        out_valid [2];
    logic [1:0]  ctrl_o [2];
    logic [63:0] lanes_o [2];
    logic [4:0]  rd_o [2];

    pkt_t q [2][$];
    logic rdy_ok [2];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.SKID(0)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
        .flush_i(flush), .ctrl_i(ctrl_i), .lanes_i(lanes_i), .rd_i(rd_i),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready),
        .ctrl_o(ctrl_o[0]), .lanes_o(lanes_o[0]), .rd_o(rd_o[0])
    );

    pipe_stage_reg #(.SKID(1)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready[1]),
        .flush_i(flush), .ctrl_i(ctrl_i), .lanes_i(lanes_i), .rd_i(rd_i),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready),
        .ctrl_o(ctrl_o[1]), .lanes_o(lanes_o[1]), .rd_o(rd_o[1])
    );

    task automatic check(input string name, input int d, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got %h expected %h", name, d, $time, act, exp);
        end
    endtask

    // monitor: compares outputs with the head of the expected FIFO and retires it on a handshake
    always @(negedge clk) begin
        int   n;
        logic exp_rdy;
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                n = q[d].size();
                exp_rdy = (d == 1) ? (n < 2) : (n == 0 || out_ready);
                check("in_ready", d, 128'(in_ready[d]), 128'(exp_rdy));
                check("out_valid", d, 128'(out_valid[d]), 128'(n > 0));
                if (n > 0)
                    check("payload", d, 128'({ctrl_o[d], lanes_o[d], rd_o[d]}), 128'(q[d][0]));
                else
                    check("bubble_ctrl", d, 128'(ctrl_o[d]), 128'd0);
                rdy_ok[d] = exp_rdy;
                if (n > 0 && out_ready && !flush)
                    void'(q[d].pop_front());
            end
        end
    end

    // drive one cycle of stimulus; expected entries are queued once the model says they were taken
    task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] l0,
                         input logic [31:0] l1, input logic [4:0] r, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        ctrl_i    = c;
        lanes_i   = {l1, l0};
        rd_i      = r;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (fl)
                q[d].delete();
            else if (v && rdy_ok[d])
                q[d].push_back({c, l1, l0, r});
        end
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, ordy, 1'b0);
    endtask

    // assert reset in the middle of a cycle and check the asynchronous clear
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_valid", d, 128'(out_valid[d]), 128'd0);
            check("rst_ctrl", d, 128'(ctrl_o[d]), 128'd0);
            check("rst_lanes", d, 128'(lanes_o[d]), 128'd0);
            check("rst_rd", d, 128'(rd_o[d]), 128'd0);
            check("rst_ready", d, 128'(in_ready[d]), 128'd1);
            q[d].delete();
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        // single push then bubble
        drive(1'b1, 2'b10, 32'hDEADBEEF, 32'h00000010, 5'd7, 1'b1, 1'b0);
        idle(1'b1, 2);
        // back-to-back streaming
        for (int i = 1; i <= 8; i++)
            drive(1'b1, 2'b11, i, i + 32'h100, 5'(i), 1'b1, 1'b0);
        idle(1'b1, 2);
        // skid fill with C held upstream, then drain
        drive(1'b1, 2'b01, 32'hA, 32'hA, 5'd10, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 32'hB, 32'hB, 5'd11, 1'b0, 1'b0);
        drive(1'b1, 2'b11, 32'hC, 32'hC, 5'd12, 1'b0, 1'b0);
        drive(1'b1, 2'b11, 32'hC, 32'hC, 5'd12, 1'b1, 1'b0);
        drive(1'b1, 2'b11, 32'hC, 32'hC, 5'd12, 1'b1, 1'b0);
        idle(1'b1, 3);
        // flush with a same-cycle push while the skid entry is occupied
        drive(1'b1, 2'b01, 32'hA, 32'hA, 5'd1, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 32'hB, 32'hB, 5'd2, 1'b0, 1'b0);
        drive(1'b1, 2'b11, 32'hF, 32'hF, 5'd15, 1'b0, 1'b1);
        idle(1'b1, 2);
        // stall hold while the upstream valid toggles
        drive(1'b1, 2'b11, 32'h5A5A5A5A, 32'hA5A5A5A5, 5'd21, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            drive(1'(i % 2), 2'b10, 32'h100 + i, 32'h200 + i, 5'(i), 1'b0, 1'b0);
        idle(1'b1, 3);
        // reset in the middle of traffic
        drive(1'b1, 2'b11, 32'h77, 32'h88, 5'd3, 1'b0, 1'b0);
        drive(1'b1, 2'b11, 32'h99, 32'hAA, 5'd4, 1'b0, 1'b0);
        do_reset();
        idle(1'b1, 2);
        // randomised traffic
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(3) != 0), 2'($urandom), $urandom, $urandom, 5'($urandom),
                  1'($urandom_range(9) < 7), 1'($urandom_range(19) == 0));
        idle(1'b1, 4);
        for (int d = 0; d < 2; d++)
            check("drained", d, 128'(q[d].size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
